// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM with retired-instruction counter
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        ir_we,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R,
    EXEC_I, WB_I, BRANCH, JUMP, JAL, JR
  } state_t;
  state_t cur, nxt;
  assign state = cur;
  // state register; reset parks the FSM in FETCH immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // next-state and Moore outputs; reset forces every output to 0
  always_comb begin
    nxt = FETCH;
    {pc_we, pc_src, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
     alu_src_a, alu_src_b, alu_op, instr_done, illegal} = '0;
    case (cur)
      FETCH: begin
        ir_we = 1'b1;
        alu_src_b = 3'd1;
        pc_we = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 3'd4;
        case (opcode)
          6'b100011, 6'b101011: nxt = MEM_ADDR;
          6'b001101, 6'b001111: nxt = EXEC_I;
          6'b000100: nxt = BRANCH;
          6'b000010: nxt = JUMP;
          6'b000011: nxt = JAL;
          6'b000000:
            case (funct)
              6'b100001, 6'b100011: nxt = EXEC_R;
              6'b001000: nxt = JR;
              6'b000000: instr_done = 1'b1;
              default: illegal = 1'b1;
            endcase
          default: illegal = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd2;
        nxt = opcode == 6'b101011 ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        iord = 1'b1;
        nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_we = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        iord = 1'b1;
        mem_we = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = funct == 6'b100011 ? 3'd1 : 3'd0;
        nxt = WB_R;
      end
      WB_R: begin
        reg_we = 1'b1;
        reg_dst = 2'd1;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd3;
        alu_op = opcode == 6'b001111 ? 3'd3 : 3'd2;
        nxt = WB_I;
      end
      WB_I: begin
        reg_we = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 3'd1;
        pc_src = 2'd1;
        pc_we = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_we = 1'b1;
        pc_src = 2'd2;
        instr_done = 1'b1;
      end
      JAL: begin
        pc_we = 1'b1;
        pc_src = 2'd2;
        reg_we = 1'b1;
        reg_dst = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
      end
      JR: begin
        pc_we = 1'b1;
        pc_src = 2'd3;
        instr_done = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    if (reset)
      {pc_we, pc_src, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
       alu_src_a, alu_src_b, alu_op, instr_done, illegal} = '0;
  end
  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) instr_cnt <= '0;
    else if (instr_done) instr_cnt <= instr_cnt + 32'd1;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: random instruction stream checked against a per-instruction control model
module tb_mips_mc_ctrl;
  logic clk = 0, reset = 1, zero = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic pc_we, iord, ir_we, mem_we, reg_we, alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_src_b, alu_op;
  logic [31:0] instr_cnt;
  logic [3:0] state;
  int passed = 0, total = 0;
  logic [31:0] cnt_model = 0;
  localparam int LW = 0, SW = 1, ADDU = 2, SUBU = 3, ORI = 4, LUI = 5, BEQ = 6,
                 J = 7, JAL = 8, JR = 9, NOP = 10, ILL = 11;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .ir_we(ir_we), .mem_we(mem_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt), .state(state)
  );

  always #5 clk = ~clk;

  wire [19:0] outs = {pc_we, pc_src, iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, alu_op, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int len_of(input int k);
    case (k)
      LW: return 5;
      SW, ADDU, SUBU, ORI, LUI: return 4;
      BEQ, J, JAL, JR: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model(input int k, input int s, input logic z,
                       output logic [3:0] st, output logic [19:0] o);
    logic pw = 0, io = 0, iw = 0, mw = 0, rw = 0, sa = 0, dn = 0, il = 0;
    logic [1:0] ps = 0, rd = 0, mr = 0;
    logic [2:0] sb = 0, op = 0;
    st = 0;
    if (s == 0) begin
      pw = 1; iw = 1; sb = 1;
    end else if (s == 1) begin
      st = 1; sb = 4; dn = k == NOP; il = k == ILL;
    end else case (k)
      LW, SW:
        if (s == 2) begin st = 2; sa = 1; sb = 2; end
        else if (k == SW) begin st = 5; io = 1; mw = 1; dn = 1; end
        else if (s == 3) begin st = 3; io = 1; end
        else begin st = 4; rw = 1; mr = 1; dn = 1; end
      ADDU, SUBU:
        if (s == 2) begin st = 6; sa = 1; op = k == SUBU ? 3'd1 : 3'd0; end
        else begin st = 7; rw = 1; rd = 1; dn = 1; end
      ORI, LUI:
        if (s == 2) begin st = 8; sa = 1; sb = 3; op = k == LUI ? 3'd3 : 3'd2; end
        else begin st = 9; rw = 1; dn = 1; end
      BEQ: begin st = 10; sa = 1; op = 1; ps = 1; pw = z; dn = 1; end
      J:   begin st = 11; pw = 1; ps = 2; dn = 1; end
      JAL: begin st = 12; pw = 1; ps = 2; rw = 1; rd = 2; mr = 2; dn = 1; end
      default: begin st = 13; pw = 1; ps = 3; dn = 1; end
    endcase
    o = {pw, ps, io, iw, mw, rw, rd, mr, sa, sb, op, dn, il};
  endtask

  function automatic bit supported_op(input logic [5:0] o);
    return o inside {6'h23, 6'h2b, 6'h00, 6'h0d, 6'h0f, 6'h04, 6'h02, 6'h03};
  endfunction

  task automatic encode(input int k);
    logic [5:0] ops[10] = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h04, 6'h02, 6'h03, 6'h00};
    logic [5:0] fns[4] = '{6'h21, 6'h23, 6'h08, 6'h00};
    funct = 6'($urandom);
    if (k < NOP) opcode = ops[k];
    if (k == ADDU) funct = fns[0];
    if (k == SUBU) funct = fns[1];
    if (k == JR) funct = fns[2];
    if (k == NOP) begin opcode = 0; funct = 0; end
    if (k == ILL) begin
      if ($urandom_range(0, 1) == 1) begin
        opcode = 0;
        while (funct inside {6'h21, 6'h23, 6'h08, 6'h00}) funct = 6'($urandom);
      end else begin
        opcode = 6'($urandom);
        while (supported_op(opcode)) opcode = 6'($urandom);
      end
    end
  endtask

  task automatic run(input int k, input logic z, input string nm);
    logic [3:0] st;
    logic [19:0] o;
    encode(k);
    zero = z;
    #1;
    check({nm, " cnt"}, instr_cnt, cnt_model);
    for (int s = 0; s < len_of(k); s++) begin
      if (s > 0) begin @(negedge clk); #1; end
      model(k, s, z, st, o);
      check({nm, " state"}, 32'(state), 32'(st));
      check({nm, " outs"}, 32'(outs), 32'(o));
    end
    @(negedge clk);
    if (k != ILL) cnt_model++;
  endtask

  initial begin
    #3;
    check("rst state", 32'(state), 0);
    check("rst cnt", instr_cnt, 0);
    check("rst outs", 32'(outs), 0);
    #8;
    @(negedge clk);
    check("rst hold outs", 32'(outs), 0);
    reset = 0;
    opcode = 6'h23;
    #1;
    check("first fetch pc_we", 32'(pc_we), 1);
    check("first fetch ir_we", 32'(ir_we), 1);
    run(LW, 0, "lw");
    run(BEQ, 1, "beq_z1");
    run(BEQ, 0, "beq_z0");
    run(JAL, 0, "jal");
    opcode = 6'h3f;
    zero = 0;
    #1;
    check("ill3f cnt", instr_cnt, cnt_model);
    @(negedge clk); #1;
    check("ill3f illegal", 32'(illegal), 1);
    check("ill3f done", 32'(instr_done), 0);
    @(negedge clk); #1;
    check("ill3f back", 32'(state), 0);
    check("ill3f cnt after", instr_cnt, cnt_model);
    run(NOP, 0, "nop");
    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 11);
      run(k, 1'($urandom), "rand");
    end
    encode(SW);
    repeat (3) @(negedge clk);
    #1;
    check("sw memwr state", 32'(state), 5);
    check("sw mem_we", 32'(mem_we), 1);
    reset = 1;
    #1;
    check("midrst mem_we", 32'(mem_we), 0);
    check("midrst state", 32'(state), 0);
    check("midrst cnt", instr_cnt, 0);
    check("midrst outs", 32'(outs), 0);
    @(negedge clk);
    reset = 0;
    cnt_model = 0;
    for (int i = 0; i < 20; i++) begin
      int k = $urandom_range(0, 11);
      run(k, 1'($urandom), "post");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
